// File: rtl/rat_pipe_pkg.sv
// Shared types for the pipeline hazard logic: scoreboard entry, forwarding
// select, interrupt FSM state and the RAW compare helper.
package rat_pipe_pkg;

  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 rf_wr;
    logic [RF_ADDR_W-1:0] wr_addr;
    logic                 is_load;
    logic                 flg_wr;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_INJECT
  } int_state_t;

  function automatic logic raw_match(input logic used,
                                     input logic [RF_ADDR_W-1:0] src,
                                     input sb_entry_t e);
    return used & e.valid & e.rf_wr & (src == e.wr_addr);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side hazard interface: the pipeline (master) presents the decoded
// instruction and events, the hazard unit (slave) returns control and selects.
interface hazard_unit_if #(
  parameter int STALL_CNT_W = 16
);
  import rat_pipe_pkg::*;

  logic                   id_valid;
  logic [RF_ADDR_W-1:0]   id_x_addr;
  logic [RF_ADDR_W-1:0]   id_y_addr;
  logic                   id_x_used;
  logic                   id_y_used;
  logic                   id_rf_wr;
  logic [RF_ADDR_W-1:0]   id_wr_addr;
  logic                   id_is_load;
  logic                   id_flg_rd;
  logic                   id_flg_wr;
  logic                   ex_branch_taken;
  logic                   int_req;
  logic                   int_en;

  logic                   stall;
  logic                   nop;
  logic                   flush_if;
  logic                   int_inject;
  fwd_sel_t               fwd_x_sel;
  fwd_sel_t               fwd_y_sel;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_x_addr, id_y_addr, id_x_used, id_y_used,
           id_rf_wr, id_wr_addr, id_is_load, id_flg_rd, id_flg_wr,
           ex_branch_taken, int_req, int_en,
    input  stall, nop, flush_if, int_inject, fwd_x_sel, fwd_y_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_x_addr, id_y_addr, id_x_used, id_y_used,
           id_rf_wr, id_wr_addr, id_is_load, id_flg_rd, id_flg_wr,
           ex_branch_taken, int_req, int_en,
    output stall, nop, flush_if, int_inject, fwd_x_sel, fwd_y_sel, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Two-entry scoreboard mirroring the EX and WB stages; a bubble is captured
// whenever the ID/EX register is being nopped.
module hazard_scoreboard
  import rat_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      capture,
  input  sb_entry_t id_entry,
  output sb_entry_t ex_entry,
  output sb_entry_t wb_entry
);

  // ID -> EX -> WB; only the valid bits need a reset value
  always_ff @(posedge clk) begin
    wb_entry       <= ex_entry;
    ex_entry       <= id_entry;
    ex_entry.valid <= id_entry.valid & capture;
    if (rst) begin
      ex_entry.valid <= 1'b0;
      wb_entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: RAW/flag stall detection, branch flush, interrupt
// drain/inject FSM and stall counter. Define HAZARD_FORWARD_EN for forwarding.
module hazard_unit
  import rat_pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t              id_entry;
  sb_entry_t              ex_entry;
  sb_entry_t              wb_entry;
  int_state_t             state;
  int_state_t             state_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   x_ex, x_wb, y_ex, y_wb;
  logic                   data_hazard;
  logic                   flag_hazard;
  logic                   stall, nop, flush_if, int_inject;
  fwd_sel_t               fwd_x, fwd_y;
  logic                   unused_fields;

  assign id_entry = '{valid:   hz.id_valid,
                      rf_wr:   hz.id_rf_wr,
                      wr_addr: hz.id_wr_addr,
                      is_load: hz.id_is_load,
                      flg_wr:  hz.id_flg_wr};

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .capture  (~nop),
    .id_entry (id_entry),
    .ex_entry (ex_entry),
    .wb_entry (wb_entry)
  );

  assign x_ex = raw_match(hz.id_x_used, hz.id_x_addr, ex_entry);
  assign x_wb = raw_match(hz.id_x_used, hz.id_x_addr, wb_entry);
  assign y_ex = raw_match(hz.id_y_used, hz.id_y_addr, ex_entry);
  assign y_wb = raw_match(hz.id_y_used, hz.id_y_addr, wb_entry);

  // Flags are written in EX, so only the EX entry can hold a pending update
  assign flag_hazard = hz.id_flg_rd & ex_entry.valid & ex_entry.flg_wr;

`ifdef HAZARD_FORWARD_EN
  // Load data only exists in WB, so a load in EX cannot feed the ALU yet
  always_comb begin
    data_hazard = (x_ex | y_ex) & ex_entry.is_load;
    fwd_x = FWD_RF;
    fwd_y = FWD_RF;
    if (x_ex && !ex_entry.is_load) fwd_x = FWD_EX;
    else if (x_wb)                 fwd_x = FWD_WB;
    if (y_ex && !ex_entry.is_load) fwd_y = FWD_EX;
    else if (y_wb)                 fwd_y = FWD_WB;
  end
`else
  assign data_hazard = x_ex | x_wb | y_ex | y_wb;
  assign fwd_x       = FWD_RF;
  assign fwd_y       = FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hz.int_req && hz.int_en) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!ex_entry.valid && !wb_entry.valid) state_nxt = ST_INJECT;
      ST_INJECT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A taken branch overrides any stall, including the drain stall
  always_comb begin
    stall      = 1'b0;
    nop        = 1'b0;
    flush_if   = 1'b0;
    int_inject = 1'b0;
    if (!rst) begin
      if (state == ST_INJECT) begin
        int_inject = 1'b1;
        stall      = 1'b1;
      end else if (hz.ex_branch_taken) begin
        flush_if = 1'b1;
        nop      = 1'b1;
      end else if (state == ST_DRAIN || data_hazard || flag_hazard) begin
        stall = 1'b1;
        nop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  assign hz.stall      = stall;
  assign hz.nop        = nop;
  assign hz.flush_if   = flush_if;
  assign hz.int_inject = int_inject;
  assign hz.fwd_x_sel  = rst ? FWD_RF : fwd_x;
  assign hz.fwd_y_sel  = rst ? FWD_RF : fwd_y;
  assign hz.stall_cnt  = stall_cnt;

  assign unused_fields = ^{wb_entry.is_load, wb_entry.flg_wr, ex_entry.is_load};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic, all checked
// against an in-bench pipeline model (instruction queue + interrupt phase flags).
module tb_hazard_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic v, wr; logic [4:0] wa; logic ld, fw, fr, xu; logic [4:0] xa;
    logic yu; logic [4:0] ya;
  } id_t;

  typedef struct packed {
    logic stall, nop, flush, inj; logic [1:0] fx, fy;
  } out_t;

  localparam id_t BUB = '0;

  logic clk;
  logic rst;
  hazard_unit_if #(.STALL_CNT_W(CW)) hz ();

  hazard_unit #(.STALL_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  id_t  cur;
  id_t  pipe[$];   // [0] = instruction in EX, [1] = instruction in WB
  bit   drn, inj_m;
  int   m_cnt;
  out_t exp, got;

  function automatic id_t mk(logic v, logic wr, logic [4:0] wa, logic ld,
                             logic fw, logic fr, logic xu, logic [4:0] xa,
                             logic yu, logic [4:0] ya);
    id_t i;
    i = '{v:v, wr:wr, wa:wa, ld:ld, fw:fw, fr:fr, xu:xu, xa:xa, yu:yu, ya:ya};
    return i;
  endfunction

  task automatic apply_id(input id_t i);
    cur = i;
    hz.id_valid = i.v;  hz.id_rf_wr = i.wr; hz.id_wr_addr = i.wa;
    hz.id_is_load = i.ld; hz.id_flg_wr = i.fw; hz.id_flg_rd = i.fr;
    hz.id_x_used = i.xu; hz.id_x_addr = i.xa;
    hz.id_y_used = i.yu; hz.id_y_addr = i.ya;
  endtask

  function automatic bit hit(logic u, logic [4:0] a, id_t e);
    return u && e.v && e.wr && (a == e.wa);
  endfunction

  function automatic out_t model_out();
    out_t o;
    bit xe, xw, ye, yw, dh, fh;
    o = '0;
    if (rst) return o;
    xe = hit(cur.xu, cur.xa, pipe[0]);
    xw = hit(cur.xu, cur.xa, pipe[1]);
    ye = hit(cur.yu, cur.ya, pipe[0]);
    yw = hit(cur.yu, cur.ya, pipe[1]);
    if (FWD) begin
      dh   = (xe || ye) && pipe[0].ld;
      o.fx = xe ? 2'b01 : (xw ? 2'b10 : 2'b00);
      o.fy = ye ? 2'b01 : (yw ? 2'b10 : 2'b00);
    end else begin
      dh = xe || xw || ye || yw;
    end
    fh = cur.fr && pipe[0].v && pipe[0].fw;
    if (inj_m) begin
      o.inj = 1'b1; o.stall = 1'b1;
    end else if (hz.ex_branch_taken) begin
      o.flush = 1'b1; o.nop = 1'b1;
    end else if (drn || dh || fh) begin
      o.stall = 1'b1; o.nop = 1'b1;
    end
    return o;
  endfunction

  // forwarding selects only matter when an instruction actually issues
  function automatic out_t mask(out_t o, logic n);
    out_t r;
    r = o;
    if (n) begin r.fx = 2'b00; r.fy = 2'b00; end
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      pipe = '{BUB, BUB}; drn = 1'b0; inj_m = 1'b0; m_cnt = 0;
    end else begin
      if (exp.stall && m_cnt < CMAX) m_cnt++;
      if (inj_m) inj_m = 1'b0;
      else if (drn) begin
        if (!pipe[0].v && !pipe[1].v) begin drn = 1'b0; inj_m = 1'b1; end
      end else if (hz.int_req && hz.int_en) drn = 1'b1;
      pipe.push_front(exp.nop ? BUB : cur);
      void'(pipe.pop_back());
    end
  endtask

  task automatic eval();
    @(negedge clk);
    exp = model_out();
    got = {hz.stall, hz.nop, hz.flush_if, hz.int_inject, hz.fwd_x_sel, hz.fwd_y_sel};
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hz.ex_branch_taken = 1'b0; hz.int_req = 1'b0; hz.int_en = 1'b0;
    apply_id(BUB);
    eval();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rnd;
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom;
      apply_id(rnd[21:0]);
      hz.ex_branch_taken = rnd[22]; hz.int_req = 1'b1; hz.int_en = 1'b1;
      eval();
      n_tests++;
      if (got !== 8'h00) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: got %b want 00000000", i, got);
      end
      adv();
    end
    rst = 1'b0;
    hz.ex_branch_taken = 1'b0; hz.int_req = 1'b0; hz.int_en = 1'b0;
    apply_id(BUB);
    eval();
    n_tests++;
    if (hz.stall_cnt !== 4'd0 || got !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: cnt %0d outs %b, want 0 / 00000000", hz.stall_cnt, got);
    end
    adv();
  endtask

  task automatic test_raw_hazards();
    id_t prod[4], cons[4];
    int nst[4];
    logic [3:0] sel[4];
    int st;
    bit seen;
    prod[0] = mk(1,1,5'd1,0,0,0,1,5'd5,1,5'd6);  cons[0] = mk(1,1,5'd2,0,0,0,1,5'd1,1,5'd7);
    nst[0] = FWD ? 0 : 2;  sel[0] = FWD ? 4'b0100 : 4'b0000;
    prod[1] = mk(1,1,5'd3,1,0,0,0,5'd0,0,5'd0);  cons[1] = mk(1,1,5'd4,0,0,0,1,5'd3,0,5'd0);
    nst[1] = FWD ? 1 : 2;  sel[1] = FWD ? 4'b1000 : 4'b0000;
    prod[2] = mk(1,0,5'd0,0,1,0,1,5'd8,1,5'd9);  cons[2] = mk(1,0,5'd0,0,0,1,0,5'd0,0,5'd0);
    nst[2] = 1;            sel[2] = 4'b0000;
    prod[3] = mk(1,1,5'd10,0,0,0,0,5'd0,0,5'd0); cons[3] = mk(1,1,5'd11,0,0,0,1,5'd1,1,5'd10);
    nst[3] = FWD ? 0 : 2;  sel[3] = FWD ? 4'b0001 : 4'b0000;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      apply_id(prod[r]);
      eval();
      n_tests++;
      if (mask(got, exp.nop) !== mask(exp, exp.nop)) begin
        n_fail++; $display("FAIL raw%0d_producer: got %b want %b", r, got, exp);
      end
      adv();
      apply_id(cons[r]);
      st = 0; seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        eval();
        n_tests++;
        if (mask(got, exp.nop) !== mask(exp, exp.nop)) begin
          n_fail++; $display("FAIL raw%0d_cycle%0d: got %b want %b", r, c, got, exp);
        end
        if (got.stall) st++;
        else if (!seen) begin
          seen = 1'b1;
          n_tests++;
          if ({got.fx, got.fy} !== sel[r]) begin
            n_fail++; $display("FAIL raw%0d_fwd_sel: got %b want %b", r, {got.fx, got.fy}, sel[r]);
          end
        end
        adv();
        if (seen) apply_id(BUB);
      end
      n_tests++;
      if (st !== nst[r]) begin
        n_fail++; $display("FAIL raw%0d_stall_cycles: got %0d want %0d", r, st, nst[r]);
      end
      eval();
      n_tests++;
      if (hz.stall_cnt !== 4'(nst[r])) begin
        n_fail++; $display("FAIL raw%0d_stall_cnt: got %0d want %0d", r, hz.stall_cnt, nst[r]);
      end
      adv();
    end
  endtask

  task automatic test_branch_cancel();
    do_reset();
    apply_id(mk(1,1,5'd3,1,0,0,0,5'd0,0,5'd0));
    eval(); adv();
    apply_id(mk(1,1,5'd4,0,0,0,1,5'd3,0,5'd0));
    hz.ex_branch_taken = 1'b1;
    eval();
    n_tests++;
    if ({got.stall, got.nop, got.flush, got.inj} !== 4'b0110 || got.stall !== exp.stall) begin
      n_fail++; $display("FAIL branch_over_stall: got %b want stall=0 nop=1 flush=1 inj=0", got);
    end
    adv();
    hz.ex_branch_taken = 1'b0;
    apply_id(BUB);
    eval();
    n_tests++;
    if (hz.stall_cnt !== 4'd0 || mask(got, exp.nop) !== mask(exp, exp.nop)) begin
      n_fail++; $display("FAIL branch_cnt: cnt %0d outs %b, want 0 / %b", hz.stall_cnt, got, exp);
    end
    adv();
  endtask

  task automatic test_interrupt();
    logic [19:0] seq;
    for (int v = 0; v < 2; v++) begin
      seq = (v == 0) ? 20'b1100_1100_1001_0000_0000 : 20'b0110_1100_1001_0000_0000;
      do_reset();
      apply_id(mk(1,1,5'd1,0,0,0,0,5'd0,0,5'd0)); eval(); adv();
      apply_id(mk(1,1,5'd2,0,0,0,0,5'd0,0,5'd0)); eval(); adv();
      apply_id(BUB);
      hz.int_req = 1'b1; hz.int_en = 1'b1;
      eval();
      n_tests++;
      if (got !== exp || got.stall !== 1'b0) begin
        n_fail++; $display("FAIL int%0d_request_cycle: got %b want %b", v, got, exp);
      end
      adv();
      hz.int_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
        hz.ex_branch_taken = (v == 1 && k == 0);
        eval();
        n_tests++;
        if ({got.stall, got.nop, got.flush, got.inj} !== seq[19-4*k -: 4] ||
            mask(got, exp.nop) !== mask(exp, exp.nop)) begin
          n_fail++;
          $display("FAIL int%0d_seq%0d: got %b want ctl %b model %b", v, k, got, seq[19-4*k -: 4], exp);
        end
        adv();
      end
      hz.ex_branch_taken = 1'b0; hz.int_en = 1'b0;
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    apply_id(mk(1,1,5'd1,0,0,0,0,5'd0,0,5'd0)); eval(); adv();
    apply_id(mk(1,1,5'd2,0,0,0,0,5'd0,0,5'd0)); eval(); adv();
    apply_id(BUB);
    hz.int_req = 1'b1; hz.int_en = 1'b1;
    eval(); adv();
    hz.int_req = 1'b0;
    eval();
    n_tests++;
    if (got.stall !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL rstdrain_in_drain: got %b want %b", got, exp);
    end
    adv();
    rst = 1'b1;
    eval();
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++; $display("FAIL rstdrain_during_rst: got %b want 00000000", got);
    end
    adv();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      eval();
      n_tests++;
      if (got !== 8'h00 || hz.stall_cnt !== 4'(m_cnt) || got !== exp) begin
        n_fail++; $display("FAIL rstdrain_after%0d: got %b cnt %0d want 00000000 cnt %0d", k, got, hz.stall_cnt, m_cnt);
      end
      adv();
    end
    hz.int_en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) apply_id(mk(1,0,5'd0,0,1,0,0,5'd0,0,5'd0));
      else if (i % 3 == 1) apply_id(mk(1,0,5'd0,0,0,1,0,5'd0,0,5'd0));
      eval();
      n_tests++;
      if (mask(got, exp.nop) !== mask(exp, exp.nop) || hz.stall_cnt !== 4'(m_cnt)) begin
        n_fail++; $display("FAIL sat_cycle%0d: got %b cnt %0d want %b cnt %0d", i, got, hz.stall_cnt, exp, m_cnt);
      end
      adv();
    end
    apply_id(BUB);
    eval();
    n_tests++;
    if (hz.stall_cnt !== 4'(CMAX)) begin
      n_fail++; $display("FAIL sat_final: got %0d want %0d", hz.stall_cnt, CMAX);
    end
    adv();
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    id_t r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      r = rnd[21:0];
      r.wa = 5'($urandom_range(0, 3));
      r.xa = 5'($urandom_range(0, 3));
      r.ya = 5'($urandom_range(0, 3));
      apply_id(r);
      rst = ($urandom_range(0, 39) == 0);
      hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
      hz.int_req = ($urandom_range(0, 9) == 0);
      hz.int_en = rnd[31];
      eval();
      n_tests++;
      if (mask(got, exp.nop) !== mask(exp, exp.nop)) begin
        n_fail++; $display("FAIL rand_outs%0d: got %b want %b", i, got, exp);
      end
      n_tests++;
      if (hz.stall_cnt !== 4'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt%0d: got %0d want %0d", i, hz.stall_cnt, m_cnt);
      end
      adv();
    end
    rst = 1'b0;
  endtask

  initial begin
    pipe = '{BUB, BUB};
    drn = 1'b0; inj_m = 1'b0; m_cnt = 0;
    rst = 1'b1;
    do_reset();
    test_reset();
    test_raw_hazards();
    test_branch_cancel();
    test_interrupt();
    test_reset_in_drain();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
